// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Fixed-latency MUL/DIV sequencing; MTHI/MTLO write HI/LO directly from IDLE.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              sgn_q, sgn_d;
    logic              busy_q, busy_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic              a_neg, b_neg, div_zero;
    logic [XLEN-1:0]   a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

    // Single-shot result datapath fed from the latched operands
    always_comb begin
        a_ext    = sgn_q ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
        b_ext    = sgn_q ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
        prod     = a_ext * b_ext;
        a_neg    = sgn_q & a_q[XLEN-1];
        b_neg    = sgn_q & b_q[XLEN-1];
        a_mag    = a_neg ? (~a_q + XLEN'(1)) : a_q;
        b_mag    = b_neg ? (~b_q + XLEN'(1)) : b_q;
        div_zero = (b_q == '0);
        // Divider sees a safe divisor; the zero case never commits a result
        b_div    = div_zero ? XLEN'(1) : b_mag;
        q_mag    = a_mag / b_div;
        r_mag    = a_mag % b_div;
        quo      = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
        rem      = a_neg ? (~r_mag + XLEN'(1)) : r_mag;
    end

    // Next-state and register update logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (mdu_op)
                        3'b000, 3'b001: begin
                            a_d     = rs_val;
                            b_d     = rt_val;
                            sgn_d   = ~mdu_op[0];
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_MUL;
                            busy_d  = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            a_d     = rs_val;
                            b_d     = rt_val;
                            sgn_d   = ~mdu_op[0];
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_DIV;
                            busy_d  = 1'b1;
                        end
                        3'b100:  hi_d = rs_val;
                        3'b101:  lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (state_q == S_MUL) begin
                        hi_d = prod[2*XLEN-1:XLEN];
                        lo_d = prod[XLEN-1:0];
                    end else if (!div_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed literal cases plus randomized traffic
// compared every cycle against a cycle-count reference model.
module tb_mdu;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic, result applied after N edges
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] m_res_hi = '0, m_res_lo = '0;
    logic        m_res_wr = 1'b0;
    int          m_left = 0;

    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic wr, output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] p;
        wr = 1'b1;
        h  = '0;
        l  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = 64'(a) * 64'(b); h = p[63:32]; l = p[31:0]; end
            3'd2: begin
                if (b == 0) wr = 1'b0;
                else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            end
            default: begin
                if (b == 0) wr = 1'b0;
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_res_wr = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_res_wr) begin
                m_hi = m_res_hi;
                m_lo = m_res_lo;
            end
        end else if (start) begin
            if (mdu_op <= 3'd3) begin
                ref_op(mdu_op, rs_val, rt_val, m_res_wr, m_res_hi, m_res_lo);
                m_left = (mdu_op <= 3'd1) ? int'(MC) : int'(DC);
            end else if (mdu_op == 3'd4) m_hi = rs_val;
            else if (mdu_op == 3'd5) m_lo = rs_val;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_busy", 32'(busy), 32'(m_left > 0));
        chk("model_hi", hi, m_hi);
        chk("model_lo", lo, m_lo);
    end

    // Issue one request at a negedge, count busy cycles, then check HI/LO
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        chk({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({name, "_hi"}, hi, exp_hi);
        chk({name, "_lo"}, lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        reset = 1'b0; start = 1'b0; mdu_op = '0; rs_val = '0; rt_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        #2 reset = 1'b1;
        @(negedge clk);

        do_op("mult",  3'd0, 32'hFFFF_FFFF, 32'h2, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h2, MC, 32'h0000_0001, 32'hFFFF_FFFE);
        do_op("div",   3'd2, 32'hFFFF_FFF9, 32'h2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu",  3'd3, 32'd7, 32'd2, DC, 32'd1, 32'd3);
        do_op("mthi_a", 3'd4, 32'hA, 32'h0, 0, 32'hA, 32'd3);
        do_op("mtlo_b", 3'd5, 32'hB, 32'h0, 0, 32'hA, 32'hB);
        do_op("divu_z", 3'd3, 32'd5, 32'd0, DC, 32'hA, 32'hB);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0, 32'h8000_0000);
        do_op("mthi", 3'd4, 32'h1234_5678, 32'h0, 0, 32'h1234_5678, 32'h8000_0000);
        do_op("rsvd", 3'd6, 32'h55, 32'h66, 0, 32'h1234_5678, 32'h8000_0000);

        // MTLO during an active MULT is dropped
        start = 1'b1; mdu_op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk);
        mdu_op = 3'd5; rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin cyc++; @(negedge clk); end
        chk("mtlo_busy_hi", hi, 32'd0);
        chk("mtlo_busy_lo", lo, 32'd12);

        // Start held through the completion edge is not accepted there
        start = 1'b1; mdu_op = 3'd0; rs_val = 32'd2; rt_val = 32'd3;
        @(negedge clk);
        mdu_op = 3'd4; rs_val = 32'h99;
        repeat (MC) @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd0);
        chk("b2b_hi", hi, 32'd0);
        chk("b2b_lo", lo, 32'd6);

        // Async reset during MUL clears state without a clock edge
        start = 1'b1; mdu_op = 3'd0; rs_val = 32'd9; rt_val = 32'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_lo", lo, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // Reset at busy cycle 4 of a DIV aborts it for good
        start = 1'b1; mdu_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_busy_late", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);

        // Randomized traffic, checked by the per-cycle comparison
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(0, 2) == 0);
            mdu_op = 3'($urandom_range(0, 7));
            rs_val = pick();
            rt_val = pick();
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
